ram_bridge_writer: RTL and testbench

- Sits directly downstream of the UART write-command parser. Consumes its parsed 32-bit address, 36-bit data and one-cycle valid strobe.
- Buffers commands in a small FIFO and range-checks each address against the frame-buffer BRAM size.
- Drives the BRAM write port for in-range commands.
- Emits one acknowledge byte per command on a ready/valid byte interface toward the UART transmitter, so the host can pace its writes.

---
 rtl/ram_bridge_writer_if.sv | 25 ++
 rtl/ram_bridge_writer.sv | 118 +++++++++++
 tb/tb_ram_bridge_writer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bridge_writer_if.sv
// Command, BRAM write-port and ack-byte signals between the UART parser/transmitter
// and ram_bridge_writer.
interface ram_bridge_writer_if #(
  parameter int ADDR_W = 17
);
  logic [31:0]       addr_in;
  logic [35:0]       data_in;
  logic              valid_in;
  logic [ADDR_W-1:0] ram_addr_out;
  logic [35:0]       ram_data_out;
  logic              ram_we_out;
  logic [7:0]        ack_data_out;
  logic              ack_valid_out;
  logic              ack_ready_in;

  modport master (
    output addr_in, data_in, valid_in, ack_ready_in,
    input  ram_addr_out, ram_data_out, ram_we_out, ack_data_out, ack_valid_out
  );

  modport slave (
    input  addr_in, data_in, valid_in, ack_ready_in,
    output ram_addr_out, ram_data_out, ram_we_out, ack_data_out, ack_valid_out
  );
endinterface

// File: rtl/ram_bridge_writer.sv
// Buffers parsed UART write commands, range-checks them against the frame-buffer BRAM,
// drives the BRAM write port and returns one 'A'/'R' ack byte per command.
module ram_bridge_writer #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 17,
  parameter int RAM_DEPTH = 76800
) (
  input  logic                    pixel_clk_in,
  input  logic                    rst_in,
  ram_bridge_writer_if.slave      bus,
  output logic [15:0]             write_count_out,
  output logic                    overflow_out,
  output logic                    range_err_out
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam int          PTR_W     = IDX_W + 1;
  localparam logic [31:0] RAM_LIMIT = 32'(RAM_DEPTH);
  localparam logic [7:0]  ACK_OK    = 8'h41;
  localparam logic [7:0]  ACK_RANGE = 8'h52;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [35:0]       data;
    logic              in_range;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  entry_t            head;
  entry_t            incoming;

  logic [ADDR_W-1:0] ram_addr_q;
  logic [35:0]       ram_data_q;
  logic              ram_we_q;
  logic [7:0]        ack_data_q;
  logic              ack_valid_q;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

  // Fullness is judged before any same-cycle pop, so a command arriving while full is dropped.
  assign push = bus.valid_in && !full;
  assign pop  = !empty && (!ack_valid_q || bus.ack_ready_in);

  assign incoming.addr     = bus.addr_in[ADDR_W-1:0];
  assign incoming.data     = bus.data_in;
  assign incoming.in_range = (bus.addr_in < RAM_LIMIT);
  assign head              = mem[rd_ptr[IDX_W-1:0]];

  // NOTE: the storage array has no reset; validity is tracked by the pointers alone,
  // which keeps the array mappable onto plain RAM/LUT storage.
  always_ff @(posedge pixel_clk_in) begin
    if (push) begin
      mem[wr_ptr[IDX_W-1:0]] <= incoming;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      ram_addr_q      <= '0;
      ram_data_q      <= '0;
      ram_we_q        <= 1'b0;
      ack_data_q      <= '0;
      ack_valid_q     <= 1'b0;
      write_count_out <= '0;
      overflow_out    <= 1'b0;
      range_err_out   <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (!incoming.in_range) begin
          range_err_out <= 1'b1;
        end
      end

      if (bus.valid_in && full) begin
        overflow_out <= 1'b1;
      end

      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        ack_valid_q <= 1'b1;
        if (head.in_range) begin
          ram_we_q        <= 1'b1;
          ram_addr_q      <= head.addr;
          ram_data_q      <= head.data;
          write_count_out <= write_count_out + 16'd1;
          ack_data_q      <= ACK_OK;
        end else begin
          ack_data_q      <= ACK_RANGE;
        end
      end else if (ack_valid_q && bus.ack_ready_in) begin
        ack_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ram_addr_out  = ram_addr_q;
  assign bus.ram_data_out  = ram_data_q;
  assign bus.ram_we_out    = ram_we_q;
  assign bus.ack_data_out  = ack_data_q;
  assign bus.ack_valid_out = ack_valid_q;

endmodule

// File: tb/tb_ram_bridge_writer.sv
// Self-checking bench for ram_bridge_writer: cycle-by-cycle vector table plus directed
// sequences for asynchronous reset and write-counter wrap.
module tb_ram_bridge_writer;

  localparam int ADDR_W = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] write_count;
  logic        overflow;
  logic        range_err;

  int checks = 0;
  int errors = 0;

  ram_bridge_writer_if #(.ADDR_W(ADDR_W)) bus ();

  ram_bridge_writer #(
    .DEPTH    (4),
    .ADDR_W   (ADDR_W),
    .RAM_DEPTH(76800)
  ) dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .bus            (bus),
    .write_count_out(write_count),
    .overflow_out   (overflow),
    .range_err_out  (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              valid;
    logic [31:0]       addr;
    logic [35:0]       data;
    logic              rdy;
    logic              we;
    logic              av;
    logic [7:0]        ad;
    logic [ADDR_W-1:0] ram_addr;
    logic [35:0]       ram_data;
    logic [15:0]       cnt;
    logic              ovf;
    logic              rerr;
    logic              chk_ram;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic valid, input logic [31:0] addr, input logic [35:0] data,
                     input logic rdy, input logic we, input logic av, input logic [7:0] ad,
                     input logic [ADDR_W-1:0] ram_addr, input logic [35:0] ram_data,
                     input logic [15:0] cnt, input logic ovf, input logic rerr,
                     input logic chk_ram);
    vec_t v;
    v.valid = valid; v.addr = addr; v.data = data; v.rdy = rdy;
    v.we = we; v.av = av; v.ad = ad; v.ram_addr = ram_addr; v.ram_data = ram_data;
    v.cnt = cnt; v.ovf = ovf; v.rerr = rerr; v.chk_ram = chk_ram;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [31:0] addr, input logic [35:0] data,
                       input logic rdy);
    bus.valid_in     = valid;
    bus.addr_in      = addr;
    bus.data_in      = data;
    bus.ack_ready_in = rdy;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int pulses;
    string nm;

    drive(1'b0, 32'h0, 36'h0, 1'b1);

    // valid addr data rdy | we av ad ram_addr ram_data cnt ovf rerr chk_ram
    // Single write, then out-of-range 76800 followed by in-range 76799.
    add(1, 32'h10,    36'h123456789, 1,  0, 0, 8'h00, 17'h0,     36'h0,         16'd0,  0, 0, 0);
    add(0, 32'h0,     36'h0,         1,  1, 1, 8'h41, 17'h10,    36'h123456789, 16'd1,  0, 0, 0);
    add(0, 32'h0,     36'h0,         1,  0, 0, 8'h00, 17'h0,     36'h0,         16'd1,  0, 0, 0);
    add(1, 32'h12C00, 36'hABC,       1,  0, 0, 8'h00, 17'h0,     36'h0,         16'd1,  0, 1, 0);
    add(1, 32'h12BFF, 36'hFEDCBA987, 1,  0, 1, 8'h52, 17'h10,    36'h123456789, 16'd1,  0, 1, 1);
    add(0, 32'h0,     36'h0,         1,  1, 1, 8'h41, 17'h12BFF, 36'hFEDCBA987, 16'd2,  0, 1, 0);
    add(0, 32'h0,     36'h0,         1,  0, 0, 8'h00, 17'h0,     36'h0,         16'd2,  0, 1, 0);
    // Four back-to-back commands with ready held high.
    add(1, 32'h100,   36'h1,         1,  0, 0, 8'h00, 17'h0,     36'h0,         16'd2,  0, 1, 0);
    add(1, 32'h101,   36'h2,         1,  1, 1, 8'h41, 17'h100,   36'h1,         16'd3,  0, 1, 0);
    add(1, 32'h102,   36'h3,         1,  1, 1, 8'h41, 17'h101,   36'h2,         16'd4,  0, 1, 0);
    add(1, 32'h103,   36'h4,         1,  1, 1, 8'h41, 17'h102,   36'h3,         16'd5,  0, 1, 0);
    add(0, 32'h0,     36'h0,         1,  1, 1, 8'h41, 17'h103,   36'h4,         16'd6,  0, 1, 0);
    add(0, 32'h0,     36'h0,         1,  0, 0, 8'h00, 17'h0,     36'h0,         16'd6,  0, 1, 0);
    // Ready low, six commands: one acked and held, four queued, one dropped.
    add(1, 32'h200,   36'h11,        0,  0, 0, 8'h00, 17'h0,     36'h0,         16'd6,  0, 1, 0);
    add(1, 32'h201,   36'h12,        0,  1, 1, 8'h41, 17'h200,   36'h11,        16'd7,  0, 1, 0);
    add(1, 32'h202,   36'h13,        0,  0, 1, 8'h41, 17'h0,     36'h0,         16'd7,  0, 1, 0);
    add(1, 32'h203,   36'h14,        0,  0, 1, 8'h41, 17'h0,     36'h0,         16'd7,  0, 1, 0);
    add(1, 32'h204,   36'h15,        0,  0, 1, 8'h41, 17'h0,     36'h0,         16'd7,  0, 1, 0);
    add(1, 32'h205,   36'h16,        0,  0, 1, 8'h41, 17'h0,     36'h0,         16'd7,  1, 1, 0);
    add(0, 32'h0,     36'h0,         0,  0, 1, 8'h41, 17'h0,     36'h0,         16'd7,  1, 1, 0);
    add(0, 32'h0,     36'h0,         1,  1, 1, 8'h41, 17'h201,   36'h12,        16'd8,  1, 1, 0);
    add(0, 32'h0,     36'h0,         1,  1, 1, 8'h41, 17'h202,   36'h13,        16'd9,  1, 1, 0);
    add(0, 32'h0,     36'h0,         1,  1, 1, 8'h41, 17'h203,   36'h14,        16'd10, 1, 1, 0);
    add(0, 32'h0,     36'h0,         1,  1, 1, 8'h41, 17'h204,   36'h15,        16'd11, 1, 1, 0);
    add(0, 32'h0,     36'h0,         1,  0, 0, 8'h00, 17'h0,     36'h0,         16'd11, 1, 1, 0);
    // Refill to full, then a command arriving while full alongside a pop is still dropped;
    // queue holds an interleaved out-of-range entry with high address bits set.
    add(1, 32'h300,   36'h21,        0,  0, 0, 8'h00, 17'h0,     36'h0,         16'd11, 1, 1, 0);
    add(1, 32'h301,   36'h22,        0,  1, 1, 8'h41, 17'h300,   36'h21,        16'd12, 1, 1, 0);
    add(1, 32'h302,   36'h23,        0,  0, 1, 8'h41, 17'h0,     36'h0,         16'd12, 1, 1, 0);
    add(1, 32'h80000010, 36'h24,     0,  0, 1, 8'h41, 17'h0,     36'h0,         16'd12, 1, 1, 0);
    add(1, 32'h304,   36'h25,        0,  0, 1, 8'h41, 17'h0,     36'h0,         16'd12, 1, 1, 0);
    add(1, 32'h305,   36'h26,        1,  1, 1, 8'h41, 17'h301,   36'h22,        16'd13, 1, 1, 0);
    add(0, 32'h0,     36'h0,         1,  1, 1, 8'h41, 17'h302,   36'h23,        16'd14, 1, 1, 0);
    add(0, 32'h0,     36'h0,         1,  0, 1, 8'h52, 17'h302,   36'h23,        16'd14, 1, 1, 1);
    add(0, 32'h0,     36'h0,         1,  1, 1, 8'h41, 17'h304,   36'h25,        16'd15, 1, 1, 0);
    add(0, 32'h0,     36'h0,         1,  0, 0, 8'h00, 17'h0,     36'h0,         16'd15, 1, 1, 0);

    // Reset state: asserted asynchronously before the first clock edge.
    #1 rst = 1'b1;
    #2;
    check("reset.we",    64'(bus.ram_we_out),    64'd0);
    check("reset.av",    64'(bus.ack_valid_out), 64'd0);
    check("reset.ad",    64'(bus.ack_data_out),  64'd0);
    check("reset.addr",  64'(bus.ram_addr_out),  64'd0);
    check("reset.data",  64'(bus.ram_data_out),  64'd0);
    check("reset.cnt",   64'(write_count),       64'd0);
    check("reset.ovf",   64'(overflow),          64'd0);
    check("reset.rerr",  64'(range_err),         64'd0);
    #9 rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].valid, vq[i].addr, vq[i].data, vq[i].rdy);
      cyc();
      nm = $sformatf("v%0d", i);
      check({nm, ".we"},   64'(bus.ram_we_out),    64'(vq[i].we));
      check({nm, ".av"},   64'(bus.ack_valid_out), 64'(vq[i].av));
      check({nm, ".cnt"},  64'(write_count),       64'(vq[i].cnt));
      check({nm, ".ovf"},  64'(overflow),          64'(vq[i].ovf));
      check({nm, ".rerr"}, 64'(range_err),         64'(vq[i].rerr));
      if (vq[i].av)
        check({nm, ".ad"}, 64'(bus.ack_data_out),  64'(vq[i].ad));
      if (vq[i].we || vq[i].chk_ram) begin
        check({nm, ".addr"}, 64'(bus.ram_addr_out), 64'(vq[i].ram_addr));
        check({nm, ".data"}, 64'(bus.ram_data_out), 64'(vq[i].ram_data));
      end
    end

    // Mid-stream asynchronous reset with three entries queued and an ack pending.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h400 + 32'(k), 36'h40 + 36'(k), 1'b0);
      cyc();
    end
    drive(1'b0, 32'h0, 36'h0, 1'b0);
    #3;
    check("midrst.pre_av",  64'(bus.ack_valid_out), 64'd1);
    check("midrst.pre_cnt", 64'(write_count),       64'd16);
    rst = 1'b1;
    #1;
    check("midrst.we",   64'(bus.ram_we_out),    64'd0);
    check("midrst.av",   64'(bus.ack_valid_out), 64'd0);
    check("midrst.ad",   64'(bus.ack_data_out),  64'd0);
    check("midrst.addr", 64'(bus.ram_addr_out),  64'd0);
    check("midrst.data", 64'(bus.ram_data_out),  64'd0);
    check("midrst.cnt",  64'(write_count),       64'd0);
    check("midrst.ovf",  64'(overflow),          64'd0);
    check("midrst.rerr", 64'(range_err),         64'd0);
    cyc();
    rst = 1'b0;
    bus.ack_ready_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check($sformatf("postrst%0d.we", k), 64'(bus.ram_we_out),    64'd0);
      check($sformatf("postrst%0d.av", k), 64'(bus.ack_valid_out), 64'd0);
    end
    drive(1'b1, 32'h50, 36'h5, 1'b1);
    cyc();
    drive(1'b0, 32'h0, 36'h0, 1'b1);
    cyc();
    check("postrst.wr_we",   64'(bus.ram_we_out),   64'd1);
    check("postrst.wr_addr", 64'(bus.ram_addr_out), 64'h50);
    check("postrst.wr_ack",  64'(bus.ack_data_out), 64'h41);
    check("postrst.wr_cnt",  64'(write_count),      64'd1);

    // Drive the counter to 0xFFFF with back-to-back writes, then wrap it.
    pulses = 0;
    for (int k = 0; k < 65534; k++) begin
      drive(1'b1, 32'(k), 36'(k), 1'b1);
      cyc();
      if (bus.ram_we_out) pulses++;
    end
    drive(1'b0, 32'h0, 36'h0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cyc();
      if (bus.ram_we_out) pulses++;
    end
    check("bulk.pulses", 64'(pulses),      64'd65534);
    check("bulk.cnt",    64'(write_count), 64'hFFFF);
    drive(1'b1, 32'h1234, 36'h9, 1'b1);
    cyc();
    drive(1'b0, 32'h0, 36'h0, 1'b1);
    cyc();
    check("wrap.we",  64'(bus.ram_we_out), 64'd1);
    check("wrap.cnt", 64'(write_count),    64'h0000);
    cyc();
    check("wrap.we_single", 64'(bus.ram_we_out), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
